vga_row_fetcher: RTL and testbench

- Upstream stage of the VGA output path. Fills the three per-colour row buffers that the VGA controller scans out.
- On each row request from the controller, reads the next display row of RGB444 pixels from a synchronous framebuffer RAM into a back buffer, then swaps it to the front.
- The front buffer drives rowbuffer_r/g/b continuously, so scan-out never sees a partially written row.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_row_fetcher_if.sv | 13 +
 rtl/vga_rowbuf.sv | 45 ++++
 rtl/vga_row_fetcher.sv | 160 ++++++++++++++++
 tb/tb_vga_row_fetcher.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared defaults, fetch-state encoding and the shift-add row base helper
// for the VGA row fetcher.
package vga_pkg;

    localparam int W        = 640;
    localparam int H        = 480;
    localparam int PIX_BITS = 4;
    localparam int ADDR_W   = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } fetch_state_e;

    // row*width as a sum of shifted copies of row, one per set bit of width;
    // width is a constant at every call site so this folds to adders only.
    function automatic logic [ADDR_W-1:0] row_base(input logic [8:0] row, input int width);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (((width >> i) & 1) != 0) begin
                acc = acc + (ADDR_W'(row) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_row_fetcher_if.sv
// Framebuffer read port: strobe and address out of the fetcher, RGB444 word
// back one cycle later.
interface vga_row_fetcher_if #(
    parameter int ADDR_W   = vga_pkg::ADDR_W,
    parameter int PIX_BITS = vga_pkg::PIX_BITS
);
    logic                    mem_rd;
    logic [ADDR_W-1:0]       mem_addr;
    logic [3*PIX_BITS-1:0]   mem_rdata;

    modport master (output mem_rd, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/vga_rowbuf.sv
// One colour channel's back/front row pair: pixels land in the back row one
// at a time, and the whole row is copied to the front on swap.
module vga_rowbuf
    import vga_pkg::*;
#(
    parameter int W        = vga_pkg::W,
    parameter int PIX_BITS = vga_pkg::PIX_BITS,
    parameter int X_W      = $clog2(W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [X_W-1:0]        wr_idx,
    input  logic [PIX_BITS-1:0]   wr_data,
    input  logic                  swap,
    output logic [W*PIX_BITS-1:0] front
);

    logic [W*PIX_BITS-1:0] back_q, back_d;
    logic [W*PIX_BITS-1:0] front_q, front_d;

    always_comb begin
        back_d  = back_q;
        front_d = front_q;
        if (wr_en) begin
            back_d[int'(wr_idx)*PIX_BITS +: PIX_BITS] = wr_data;
        end
        if (swap) begin
            front_d = back_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            back_q  <= '0;
            front_q <= '0;
        end else begin
            back_q  <= back_d;
            front_q <= front_d;
        end
    end

    assign front = front_q;

endmodule

// File: rtl/vga_row_fetcher.sv
// Fetches the next display row into per-channel back buffers and swaps it to
// the front. Define VGA_TEST_PATTERN_EN to replace memory data with colour bars.
module vga_row_fetcher
    import vga_pkg::*;
#(
    parameter int W        = vga_pkg::W,
    parameter int H        = vga_pkg::H,
    parameter int PIX_BITS = vga_pkg::PIX_BITS,
    parameter int ADDR_W   = vga_pkg::ADDR_W
) (
    input  logic                  clk_25,
    input  logic                  rst_n,
    input  logic [8:0]            currentRow,
    input  logic                  requestRow,
    vga_row_fetcher_if.master     mem,
    output logic [W*PIX_BITS-1:0] rowbuffer_r,
    output logic [W*PIX_BITS-1:0] rowbuffer_g,
    output logic [W*PIX_BITS-1:0] rowbuffer_b,
    output logic                  row_valid,
    output logic [8:0]            row_index,
    output logic                  overrun
);

    localparam int X_W = $clog2(W);

    fetch_state_e          state_q, state_d;
    logic [8:0]            tgt_q, tgt_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [X_W-1:0]        x_q, x_d;
    logic                  wr_en_q, wr_en_d;
    logic [X_W-1:0]        wr_idx_q, wr_idx_d;
    logic                  row_valid_q, row_valid_d;
    logic [8:0]            row_index_q, row_index_d;
    logic                  overrun_q, overrun_d;

    logic [8:0]            next_row;
    logic                  mem_rd_c;
    logic [ADDR_W-1:0]     mem_addr_c;
    logic                  swap_c;
    logic [3*PIX_BITS-1:0] pix_data;
    logic [W*PIX_BITS-1:0] front [3];

    // Out-of-range rows behave like the last row, so they wrap to row 0.
    assign next_row = (int'(currentRow) >= H - 1) ? 9'd0 : currentRow + 9'd1;

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        base_d      = base_q;
        x_d         = x_q;
        wr_en_d     = 1'b0;
        wr_idx_d    = x_q;
        row_valid_d = 1'b0;
        row_index_d = row_index_q;
        overrun_d   = overrun_q;
        mem_rd_c    = 1'b0;
        mem_addr_c  = '0;
        swap_c      = 1'b0;

        if (requestRow && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (requestRow) begin
                    tgt_d   = next_row;
                    base_d  = row_base(next_row, W);
                    x_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
`ifdef VGA_TEST_PATTERN_EN
                mem_rd_c   = 1'b0;
`else
                mem_rd_c   = 1'b1;
                mem_addr_c = base_q + ADDR_W'(x_q);
`endif
                wr_en_d = 1'b1;
                x_d     = x_q + 1'b1;
                if (x_q == X_W'(W - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = SWAP;
            end
            SWAP: begin
                swap_c      = 1'b1;
                row_valid_d = 1'b1;
                row_index_d = tgt_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            base_q      <= '0;
            x_q         <= '0;
            wr_en_q     <= 1'b0;
            wr_idx_q    <= '0;
            row_valid_q <= 1'b0;
            row_index_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            base_q      <= base_d;
            x_q         <= x_d;
            wr_en_q     <= wr_en_d;
            wr_idx_q    <= wr_idx_d;
            row_valid_q <= row_valid_d;
            row_index_q <= row_index_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal bars; bar number bits 2/1/0 light R/G/B respectively.
    logic [2:0] bar;
    always_comb begin
        bar      = 3'(int'(wr_idx_q) / (W / 8));
        pix_data = {{PIX_BITS{bar[2]}}, {PIX_BITS{bar[1]}}, {PIX_BITS{bar[0]}}};
    end
`else
    assign pix_data = mem.mem_rdata;
`endif

    // Channel 0 is blue (low bits), channel 2 is red.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        vga_rowbuf #(
            .W        (W),
            .PIX_BITS (PIX_BITS),
            .X_W      (X_W)
        ) u_rowbuf (
            .clk     (clk_25),
            .rst_n   (rst_n),
            .wr_en   (wr_en_q),
            .wr_idx  (wr_idx_q),
            .wr_data (pix_data[gi*PIX_BITS +: PIX_BITS]),
            .swap    (swap_c),
            .front   (front[gi])
        );
    end

    assign mem.mem_rd   = mem_rd_c;
    assign mem.mem_addr = mem_addr_c;
    assign rowbuffer_r  = front[2];
    assign rowbuffer_g  = front[1];
    assign rowbuffer_b  = front[0];
    assign row_valid    = row_valid_q;
    assign row_index    = row_index_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_vga_row_fetcher.sv
// Self-checking bench for vga_row_fetcher: framebuffer model returns addr[11:0],
// expected read addresses are queued per request and popped on each mem_rd.
module tb_vga_row_fetcher;
    import vga_pkg::*;

    localparam int PB = PIX_BITS;
    localparam int RB = W * PB;

    logic          clk_25 = 1'b0;
    logic          rst_n = 1'b0;
    logic [8:0]    currentRow = '0;
    logic          requestRow = 1'b0;
    logic [RB-1:0] rb_r, rb_g, rb_b;
    logic          row_valid;
    logic [8:0]    row_index;
    logic          overrun;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic          ovr_exp = 1'b0;
    int unsigned   addr_q[$];

    vga_row_fetcher_if mem_if ();

    vga_row_fetcher dut (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .currentRow  (currentRow),
        .requestRow  (requestRow),
        .mem         (mem_if),
        .rowbuffer_r (rb_r),
        .rowbuffer_g (rb_g),
        .rowbuffer_b (rb_b),
        .row_valid   (row_valid),
        .row_index   (row_index),
        .overrun     (overrun)
    );

    always #5 clk_25 = ~clk_25;

    always @(posedge clk_25) begin
        if (mem_if.mem_rd) mem_if.mem_rdata <= mem_if.mem_addr[11:0];
    end

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    function automatic logic [11:0] exp_word(input int tgt, input int x);
        logic [2:0] bar;
`ifdef VGA_TEST_PATTERN_EN
        bar = 3'(x / (W / 8));
        return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`else
        bar = '0;
        return 12'((tgt * W + x) & 'hFFF);
`endif
    endfunction

    task automatic check_front(input int tgt, input string name);
        logic [RB-1:0] er, eg, eb;
        logic [11:0]   w;
        int            first;
        for (int x = 0; x < W; x++) begin
            w = exp_word(tgt, x);
            er[x*PB +: PB] = w[11:8];
            eg[x*PB +: PB] = w[7:4];
            eb[x*PB +: PB] = w[3:0];
        end
        n_cmp++;
        if (rb_r !== er || rb_g !== eg || rb_b !== eb) begin
            n_bad++;
            first = -1;
            for (int x = W - 1; x >= 0; x--) begin
                if (rb_r[x*PB +: PB] !== er[x*PB +: PB] || rb_g[x*PB +: PB] !== eg[x*PB +: PB] ||
                    rb_b[x*PB +: PB] !== eb[x*PB +: PB]) first = x;
            end
            $display("FAIL %s front pixel %0d: got rgb=%h/%h/%h want %h/%h/%h", name, first,
                     rb_r[first*PB +: PB], rb_g[first*PB +: PB], rb_b[first*PB +: PB],
                     er[first*PB +: PB], eg[first*PB +: PB], eb[first*PB +: PB]);
        end else begin
            $display("front %s: row %0d contents ok", name, tgt);
        end
    endtask

    task automatic test_reset();
        int bad_rd;
        int bad_out;
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (mem_if.mem_rd !== 1'b0 || mem_if.mem_addr !== '0 || row_valid !== 1'b0 ||
            row_index !== 9'd0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rd=%b addr=%0d valid=%b idx=%0d ovr=%b want all 0",
                     mem_if.mem_rd, mem_if.mem_addr, row_valid, row_index, overrun);
        end
        n_cmp++;
        if ((rb_r | rb_g | rb_b) !== '0) begin
            n_bad++;
            $display("FAIL reset_front: got nonzero front buffer want 0");
        end
        rst_n = 1'b1;
        bad_rd = 0;
        bad_out = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_if.mem_rd !== 1'b0) bad_rd++;
            if (row_valid !== 1'b0 || overrun !== 1'b0 || (rb_r | rb_g | rb_b) !== '0) bad_out++;
        end
        n_cmp++;
        if (bad_rd !== 0) begin
            n_bad++;
            $display("FAIL idle_mem_rd: got %0d cycles with mem_rd=1 want 0", bad_rd);
        end
        n_cmp++;
        if (bad_out !== 0) begin
            n_bad++;
            $display("FAIL idle_outputs: got %0d cycles with nonzero outputs want 0", bad_out);
        end
        $display("reset: idle 10 cycles checked");
    endtask

    // One row request; inject_at >= 0 adds a second request that many cycles in.
    task automatic run_fetch(input logic [8:0] cur, input int tgt, input int inject_at,
                             input string name);
        int              valid_cnt;
        int              valid_at;
        int              rd_seen;
        int unsigned     ea;
        logic [3*RB-1:0] snap;
        addr_q.delete();
`ifndef VGA_TEST_PATTERN_EN
        for (int x = 0; x < W; x++) addr_q.push_back(int'(tgt * W + x));
`endif
        snap = {rb_r, rb_g, rb_b};
        currentRow = cur;
        requestRow = 1'b1;
        tick();
        requestRow = 1'b0;
        valid_cnt = 0;
        valid_at = -1;
        rd_seen = 0;
        for (int c = 0; c < 700; c++) begin
            if (c == inject_at) begin
                currentRow = cur + 9'd7;
                requestRow = 1'b1;
                ovr_exp = 1'b1;
            end else begin
                requestRow = 1'b0;
            end
            if (mem_if.mem_rd === 1'b1) begin
                rd_seen++;
                n_cmp++;
                if (addr_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s extra_read: got mem_rd at addr %0d cycle %0d want none",
                             name, mem_if.mem_addr, c);
                end else begin
                    ea = addr_q.pop_front();
                    if (mem_if.mem_addr !== ADDR_W'(ea)) begin
                        n_bad++;
                        $display("FAIL %s mem_addr cycle %0d: got %0d want %0d",
                                 name, c, mem_if.mem_addr, ea);
                    end
                end
            end
            if (row_valid === 1'b1) begin
                valid_cnt++;
                if (valid_at < 0) valid_at = c;
            end
            if (c == W + 1) begin
                n_cmp++;
                if ({rb_r, rb_g, rb_b} !== snap) begin
                    n_bad++;
                    $display("FAIL %s front_stable: front changed before swap edge", name);
                end
            end
            tick();
        end
        requestRow = 1'b0;
        n_cmp++;
        if (addr_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s missing_reads: got %0d reads want %0d", name, rd_seen, W);
        end
`ifdef VGA_TEST_PATTERN_EN
        n_cmp++;
        if (rd_seen != 0) begin
            n_bad++;
            $display("FAIL %s pattern_mem_rd: got %0d reads want 0", name, rd_seen);
        end
`endif
        n_cmp++;
        if (valid_cnt != 1 || valid_at != W + 2) begin
            n_bad++;
            $display("FAIL %s row_valid: got %0d pulses first at %0d want 1 at %0d",
                     name, valid_cnt, valid_at, W + 2);
        end
        n_cmp++;
        if (row_index !== 9'(tgt)) begin
            n_bad++;
            $display("FAIL %s row_index: got %0d want %0d", name, row_index, tgt);
        end
        n_cmp++;
        if (overrun !== ovr_exp) begin
            n_bad++;
            $display("FAIL %s overrun: got %b want %b", name, overrun, ovr_exp);
        end
        check_front(tgt, name);
        $display("fetch %s: cur=%0d tgt=%0d reads=%0d valid_at=%0d idx=%0d ovr=%b",
                 name, cur, tgt, rd_seen, valid_at, row_index, overrun);
    endtask

    task automatic test_fetch_row4();
        run_fetch(9'd4, 5, -1, "row4");
    endtask

    task automatic test_wrap();
        run_fetch(9'd479, 0, -1, "wrap479");
    endtask

    task automatic test_overrun();
        run_fetch(9'd100, 101, 100, "overrun");
    endtask

    task automatic test_out_of_range();
        run_fetch(9'd500, 0, -1, "row500");
    endtask

    task automatic test_back_to_back();
        run_fetch(9'd9, 10, -1, "b2b_a");
        run_fetch(9'd10, 11, -1, "b2b_b");
    endtask

    task automatic test_reset_mid_fetch();
        int bad;
        currentRow = 9'd20;
        requestRow = 1'b1;
        tick();
        requestRow = 1'b0;
        for (int c = 0; c < 300; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ovr_exp = 1'b0;
        n_cmp++;
        if (mem_if.mem_rd !== 1'b0 || row_valid !== 1'b0 || overrun !== 1'b0 || row_index !== 9'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got rd=%b valid=%b ovr=%b idx=%0d want 0/0/0/0",
                     mem_if.mem_rd, row_valid, overrun, row_index);
        end
        n_cmp++;
        if ((rb_r | rb_g | rb_b) !== '0) begin
            n_bad++;
            $display("FAIL midreset_front: got nonzero front buffer want 0");
        end
        bad = 0;
        for (int c = 0; c < 700; c++) begin
            tick();
            if (mem_if.mem_rd !== 1'b0 || row_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL midreset_aborted: got %0d active cycles after reset want 0", bad);
        end
        $display("reset mid-fetch: fetch aborted, buffers cleared");
    endtask

    initial begin
        test_reset();
        test_fetch_row4();
        test_wrap();
        test_overrun();
        test_reset_mid_fetch();
        test_out_of_range();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
